// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF challenge-response controller.
// Holds the sequencer state encoding, default timing values and a width helper.
package puf_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRST = 3'd1,
      GAP  = 3'd2,
      EN   = 3'd3,
      SAMP = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam int DEF_RST_CYC    = 2;
   localparam int DEF_SETTLE_CYC = 8;
   localparam int DEF_NUM_EVAL   = 5;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a W-bit asynchronous bus.
// Latency 2 cycles, no backpressure; each bit is synchronized independently.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/puf_crp_controller.sv
// Sequences NUM_EVAL reset/enable/sample evaluations of an arbiter PUF and majority-votes each bit.
// Latency NUM_EVAL*(RST_CYC+SETTLE_CYC+2) cycles from accept; one challenge in flight, response held until taken.
module puf_crp_controller
   import puf_pkg::*;
#(
   parameter int C_BITS     = 4,
   parameter int R_BITS     = 4,
   parameter int RST_CYC    = DEF_RST_CYC,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int NUM_EVAL   = DEF_NUM_EVAL
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chal_valid,
   output logic              chal_ready,
   input  logic [C_BITS-1:0] chal_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [R_BITS-1:0] resp_data,
   output logic              resp_stable,
   output logic              busy,
   output logic              puf_reset,
   output logic              puf_enable,
   output logic [C_BITS-1:0] puf_challenge,
   input  logic [R_BITS-1:0] puf_resp
);

   localparam int CW = clog2(NUM_EVAL + 1);
   localparam int PW = clog2((RST_CYC > SETTLE_CYC ? RST_CYC : SETTLE_CYC) + 1);

   state_t            state, state_nxt;
   logic [PW-1:0]     phase;
   logic [CW-1:0]     eval_cnt;
   logic [CW-1:0]     ones [R_BITS];
   logic [R_BITS-1:0] resp_sync;
   logic [R_BITS-1:0] vote;
   logic              stable_all;
   logic              accept;

   sync_2ff #(.W(R_BITS)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (puf_resp),
      .q       (resp_sync)
   );

   assign accept = chal_valid && chal_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = PRST;
         PRST:    if (phase == PW'(RST_CYC - 1)) state_nxt = GAP;
         GAP:     state_nxt = EN;
         EN:      if (phase == PW'(SETTLE_CYC - 1)) state_nxt = SAMP;
         SAMP:    state_nxt = (eval_cnt == CW'(NUM_EVAL - 1)) ? DONE : PRST;
         DONE:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A bit is stable only if every evaluation returned the same value.
   always_comb begin
      vote       = '0;
      stable_all = 1'b1;
      for (int b = 0; b < R_BITS; b++) begin
         vote[b] = (ones[b] > CW'(NUM_EVAL / 2));
         if (!((ones[b] == '0) || (ones[b] == CW'(NUM_EVAL)))) stable_all = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase         <= '0;
         eval_cnt      <= '0;
         puf_challenge <= '0;
         puf_reset     <= 1'b0;
         puf_enable    <= 1'b0;
         chal_ready    <= 1'b0;
         busy          <= 1'b0;
         resp_valid    <= 1'b0;
         for (int b = 0; b < R_BITS; b++) ones[b] <= '0;
      end else begin
         if (state_nxt != state)                phase <= '0;
         else if (state == PRST || state == EN) phase <= phase + 1'b1;

         if (state == IDLE && accept) begin
            puf_challenge <= chal_data;
            eval_cnt      <= '0;
            for (int b = 0; b < R_BITS; b++) ones[b] <= '0;
         end

         if (state == SAMP) begin
            eval_cnt <= eval_cnt + 1'b1;
            for (int b = 0; b < R_BITS; b++) ones[b] <= ones[b] + CW'(resp_sync[b]);
         end

         // Strobes are registered from the next state so the PUF pins never glitch.
         puf_reset  <= (state_nxt == PRST);
         puf_enable <= (state_nxt == EN);
         chal_ready <= (state_nxt == IDLE);
         busy       <= (state_nxt != IDLE);
         resp_valid <= (state_nxt == DONE);
      end
   end

   assign resp_data   = resp_valid ? vote : '0;
   assign resp_stable = resp_valid & stable_all;

endmodule

// File: tb/tb_puf_crp_controller.sv
// Bench for puf_crp_controller with a behavioural stub PUF; expected responses are queued at issue
// and a negedge monitor pops and compares them on each response handshake.
module tb_puf_crp_controller;

   localparam int LAT     = 60;
   localparam int RST_CYC = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       chal_valid = 1'b0;
   logic       chal_ready;
   logic [3:0] chal_data = 4'h0;
   logic       resp_valid;
   logic       resp_ready = 1'b1;
   logic [3:0] resp_data;
   logic       resp_stable;
   logic       busy;
   logic       puf_reset;
   logic       puf_enable;
   logic [3:0] puf_challenge;
   logic [3:0] puf_resp;

   typedef struct packed {
      logic [3:0] data;
      logic       stable;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   mode     = 0;
   int   ev_cnt   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   int   rst_run  = 0;
   int   overlap_err = 0;
   int   chal_err    = 0;

   always #5 clk = ~clk;

   puf_crp_controller dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .chal_valid    (chal_valid),
      .chal_ready    (chal_ready),
      .chal_data     (chal_data),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_stable   (resp_stable),
      .busy          (busy),
      .puf_reset     (puf_reset),
      .puf_enable    (puf_enable),
      .puf_challenge (puf_challenge),
      .puf_resp      (puf_resp)
   );

   function automatic logic [3:0] model(input logic [3:0] c);
      return {c[0], c[3:1]} ^ 4'h6;
   endfunction

   // Stub PUF: fixed pattern, odd/even alternating pattern, or a fixed function of the challenge.
   assign puf_resp = (mode == 0) ? 4'b1010 :
                     (mode == 1) ? (((ev_cnt % 2) == 1) ? 4'b0001 : 4'b0000) :
                                   model(puf_challenge);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: eval tracking for the stub, protocol checks and scoreboard pops.
   initial begin
      logic       prev_busy, prev_rst, prev_valid;
      logic [3:0] prev_chal;
      exp_t       e;
      prev_busy = 1'b0; prev_rst = 1'b0; prev_valid = 1'b0; prev_chal = 4'h0;
      forever begin
         @(negedge clk);
         if (busy && !prev_busy) begin
            ev_cnt  = 0;
            acc_cyc = cyc;
         end
         if (puf_reset && !prev_rst) ev_cnt++;
         if (puf_reset && puf_enable) overlap_err++;
         if (busy && prev_busy && puf_challenge !== prev_chal) chal_err++;
         if (!reset_n) rst_run = 0;
         else if (puf_reset) rst_run++;
         else if (rst_run > 0) begin
            check("puf_reset_width", rst_run, RST_CYC);
            rst_run = 0;
         end
         if (resp_valid && !prev_valid) check("latency", cyc - acc_cyc, LAT);
         if (resp_valid && resp_ready) begin
            if (sb_q.size() == 0) check("unexpected_resp", 1, 0);
            else begin
               e = sb_q.pop_front();
               check("resp_data", resp_data, e.data);
               check("resp_stable", resp_stable, e.stable);
            end
         end
         prev_busy  = busy;
         prev_rst   = puf_reset;
         prev_valid = resp_valid;
         prev_chal  = puf_challenge;
      end
   end

   task automatic send(input logic [3:0] c, input logic [3:0] d, input logic s);
      int t;
      sb_q.push_back({d, s});
      @(posedge clk); #1;
      chal_valid = 1'b1;
      chal_data  = c;
      t = 0;
      while (!chal_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check("chal_ready_timeout", 0, 1);
      @(posedge clk); #1;
      chal_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || !chal_ready) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 300) check("response_timeout", 0, 1);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {chal_ready, busy, resp_valid, resp_stable, puf_reset, puf_enable,
                   resp_data, puf_challenge}, 32'h0);
   endtask

   initial begin
      int t;
      // Reset state and release.
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset_outputs");
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset", {chal_ready, busy}, 2'b10);

      // Fixed response; challenge traffic while busy must be ignored.
      mode = 0;
      send(4'h3, 4'b1010, 1'b1);
      repeat (5) @(posedge clk);
      #1 chal_valid = 1'b1;
      chal_data = 4'hF;
      repeat (10) @(posedge clk);
      #1 chal_valid = 1'b0;
      check("challenge_held", puf_challenge, 4'h3);
      wait_done();

      // Disagreeing evaluations: 3 of 5 ones on bit 0.
      mode = 1;
      send(4'h5, 4'b0001, 1'b0);
      wait_done();

      // Consumer stalls in DONE for 10 cycles.
      mode = 0;
      resp_ready = 1'b0;
      send(4'h9, 4'b1010, 1'b1);
      t = 0;
      while (!resp_valid && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check("stall_valid_timeout", 0, 1);
      for (int i = 0; i < 10; i++) begin
         check("stall_hold", {resp_valid, resp_data, resp_stable, chal_ready, busy}, 8'b1_1010_1_0_1);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("post_handshake", {resp_valid, chal_ready, busy}, 3'b010);

      // Abort during eval 2 with reset; partial response is discarded.
      send(4'h7, 4'b1010, 1'b1);
      t = 0;
      while (ev_cnt < 3 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check("eval2_timeout", 0, 1);
      repeat (5) @(posedge clk);
      #1 reset_n = 1'b0;
      #1 check_all_zero("abort_outputs");
      repeat (2) @(posedge clk);
      #1 check_all_zero("abort_held");
      sb_q.delete();
      reset_n = 1'b1;
      send(4'hC, 4'b1010, 1'b1);
      wait_done();
      check("chal_after_abort", puf_challenge, 4'hC);

      // Challenge-dependent stub, full sweep twice.
      mode = 2;
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < 16; c++) begin
            send(4'(c), model(4'(c)), 1'b1);
            wait_done();
         end
      end

      check("enable_reset_overlap", overlap_err, 0);
      check("challenge_change_busy", chal_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
